// File: rtl/multi_tau_ram_reader_if.sv
// Host readout and channel-RAM bus for the multi-tau correlator readout engine.
// The master side is the host plus the RAM array; the slave side is the reader.
interface multi_tau_ram_reader_if #(
  parameter int N_CH    = 5,
  parameter int DATA_W  = 32,
  parameter int BASE_AW = 5
);
  localparam int ADDR_W = BASE_AW + N_CH - 1;

  logic                     rd_req;
  logic [15:0]              rd_addr;
  logic [9:0]               burst_len;
  logic                     rd_busy;
  logic                     rd_valid;
  logic [DATA_W-1:0]        rd_data;
  logic                     rd_last;
  logic                     rd_err;
  logic [N_CH-1:0]          ram_en;
  logic [ADDR_W-1:0]        ram_addr;
  logic [N_CH*DATA_W-1:0]   ram_data;

  modport master (
    output rd_req, rd_addr, burst_len, ram_data,
    input  rd_busy, rd_valid, rd_data, rd_last, rd_err, ram_en, ram_addr
  );

  modport slave (
    input  rd_req, rd_addr, burst_len, ram_data,
    output rd_busy, rd_valid, rd_data, rd_last, rd_err, ram_en, ram_addr
  );
endinterface

// File: rtl/multi_tau_ram_reader.sv
// Burst readout engine for the multi-tau correlator result RAMs: decodes channel
// and offset, issues wrapping synchronous-RAM reads and returns registered beats.
module multi_tau_ram_reader #(
  parameter int          N_CH         = 5,
  parameter int          DATA_W       = 32,
  parameter int          BASE_AW      = 5,
  parameter int          RAM_LAT      = 1,
  parameter logic [31:0] DEFAULT_DATA = 32'hAAAAAAAA
) (
  input logic clk,
  input logic rst_n,
  multi_tau_ram_reader_if.slave bus
);
  localparam int ADDR_W = BASE_AW + N_CH - 1;
  localparam logic [DATA_W-1:0] DEFAULT_WORD = DATA_W'(DEFAULT_DATA);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, ERR} state_t;

  // One read in flight: travels alongside the RAM access so the return stage
  // knows which slice to pick and how to flag the beat.
  typedef struct packed {
    logic       valid;
    logic       last;
    logic       err;
    logic [3:0] ch;
  } beat_t;

  state_t state, stateNext;

  logic [3:0]        reqSel;
  logic [11:0]       reqOff;
  logic [31:0]       reqMask;
  logic              reqValid;
  logic              accept;

  logic [N_CH-1:0]   ramEn;
  logic [ADDR_W-1:0] ramAddr;
  logic [ADDR_W-1:0] wrapMask;
  logic [9:0]        beatsLeft;
  logic [3:0]        chIdx;
  beat_t             iss;
  beat_t             pipe [RAM_LAT];
  beat_t             tail;

  logic              rdValid;
  logic              rdLast;
  logic              rdErr;
  logic [DATA_W-1:0] rdData;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    reqSel   = bus.rd_addr[15:12];
    reqOff   = bus.rd_addr[11:0];
    reqMask  = '0;
    reqValid = 1'b0;
    if (reqSel != 4'd0 && int'(reqSel) <= N_CH) begin
      reqMask  = (32'd1 << (BASE_AW + int'(reqSel) - 1)) - 32'd1;
      reqValid = (32'(reqOff) & ~reqMask) == 32'd0;
    end
  end

  assign accept = (state == IDLE) && bus.rd_req;
  assign tail   = pipe[RAM_LAT-1];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:  if (bus.rd_req) stateNext = reqValid ? ISSUE : ERR;
      ISSUE: if (beatsLeft == 10'd0) stateNext = DRAIN;
      DRAIN: if (rdValid && rdLast) stateNext = IDLE;
      ERR:   if (rdValid && rdLast) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Issue stage: one enable per cycle, address wraps inside the channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramEn     <= '0;
      ramAddr   <= '0;
      wrapMask  <= '0;
      beatsLeft <= '0;
      chIdx     <= '0;
      iss       <= '0;
    end else begin
      iss <= '0;
      if (accept) begin
        if (reqValid) begin
          ramEn     <= N_CH'(1) << (reqSel - 4'd1);
          ramAddr   <= ADDR_W'(reqOff);
          wrapMask  <= ADDR_W'(reqMask);
          beatsLeft <= bus.burst_len;
          chIdx     <= reqSel - 4'd1;
          iss       <= '{valid: 1'b1, last: (bus.burst_len == 10'd0),
                         err: 1'b0, ch: reqSel - 4'd1};
        end else begin
          iss <= '{valid: 1'b1, last: 1'b1, err: 1'b1, ch: 4'd0};
        end
      end else if (state == ISSUE) begin
        if (beatsLeft == 10'd0) begin
          ramEn <= '0;
        end else begin
          ramAddr   <= (ramAddr + ADDR_W'(1)) & wrapMask;
          beatsLeft <= beatsLeft - 10'd1;
          iss       <= '{valid: 1'b1, last: (beatsLeft == 10'd1),
                         err: 1'b0, ch: chIdx};
        end
      end
    end
  end

  // NOTE: this delay line is a handful of flops, not a RAM, so it is reset;
  // that is what guarantees no stale beat emerges after a mid-burst reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < RAM_LAT; j++) pipe[j] <= '0;
    end else begin
      pipe[0] <= iss;
      for (int j = 1; j < RAM_LAT; j++) pipe[j] <= pipe[j-1];
    end
  end

  // Return stage: rd_data only loads on a beat, so it holds between beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdValid <= 1'b0;
      rdLast  <= 1'b0;
      rdErr   <= 1'b0;
      rdData  <= '0;
    end else begin
      rdValid <= tail.valid;
      rdLast  <= tail.valid & tail.last;
      rdErr   <= tail.valid & tail.err;
      if (tail.valid) begin
        rdData <= tail.err ? DEFAULT_WORD
                           : bus.ram_data[int'(tail.ch)*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.rd_busy  = (state != IDLE);
  assign bus.rd_valid = rdValid;
  assign bus.rd_last  = rdLast;
  assign bus.rd_err   = rdErr;
  assign bus.rd_data  = rdData;
  assign bus.ram_en   = ramEn;
  assign bus.ram_addr = ramAddr;
endmodule
